bcd_sseg_scan: RTL and testbench
================================

# bcd_sseg_scan

Time-multiplexed 4-digit seven-segment scan driver that consumes the 12-bit, 3-digit packed BCD value produced by the BCD incrementor stage, plus its overflow indication. It snapshots the value on a load strobe and refreshes one digit at a time on active-low anode and segment lines. Leading-zero blanking is optional, and the fourth digit serves as a status digit. It sits between the BCD arithmetic datapath and the board display pins.

## Interface
- N, default 18: refresh counter width. Digit select is the top 2 bits, so each digit is held 2^(N-2) cycles. Benches use N=4.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  on a rising edge with load=1, capture bcd_in and ovf_in.
- bcd_in  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- ovf_in  in  1  overflow flag from upstream (999 wrapped to 000).
- blank_lz  in  1  1 = blank leading zeros on hundreds and tens.
- an  out  4  active-low digit enables; an[0] = ones … an[3] = status.
- sseg  out  8  active-low segments: [7] dp, [6:0] = a,b,c,d,e,f,g (a at bit 6).
- bcd_err  out  1  high while any latched nibble is >9.

## Operation
- **Snapshot register** (12 b value, 1 b ovf):
  - Loaded only on load=1.
  - The display never tears mid-scan.
  - bcd_in is ignored when load=0.
- **Refresh counter**: N-bit, free-running, wraps 2^N-1 → 0. sel = cnt[N-1:N-2].
- **Per-digit content**, selected by sel:
  - 0: ones digit, never blanked.
  - 1: tens digit. Blanked when blank_lz=1, hundreds=0 and tens=0.
  - 2: hundreds digit. Blanked when blank_lz=1 and hundreds=0.
  - 3: status digit. Shows a dash (g only, 7'b1111110) when the latched ovf=1; otherwise blanked.
- **Blanked digit**: its an bit stays 1 and sseg=8'hFF. The unselected an bits are always 1, and exactly one an bit is 0 at a time for a non-blanked digit.
- **Decode** (active low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any nibble 10–15 displays "E" = 0110000 and is never blanked.
  - bcd_err = OR of (nibble>9) over the three latched nibbles.
- **dp**: always 1 (off).
- **blank_lz**: sampled live, not latched. A change takes effect on the next refresh of the affected digit.

## Timing
- **Reset values**: an=4'b1111, sseg=8'hFF, bcd_err=0, snapshot=0, ovf=0, cnt=0.
- **Registered outputs**: an and sseg come from registers (glitch-free), so they reflect sel from the previous cycle.
  - First edge after reset release: an=1110, sseg=8'b1_0000001 (ones "0").
- **Load latency**: load sampled at edge k updates the snapshot at edge k. The selected digit's an/sseg reflect the new value at edge k+1; bcd_err updates at edge k.
- **Back-to-back loads**: each cycle overwrites the snapshot; the last one wins.
- **Reset mid-scan or simultaneous with load**: reset wins, and all state returns to reset values immediately (asynchronously).
- **Digit sequence**: 0,1,2,3,0,…, each held exactly 2^(N-2) cycles. The transition happens at the cnt rollover of bits [N-3:0].

## Structure
- **Shared package** `sseg_pkg`:
  - Segment constants SEG_BLANK=7'h7F, SEG_DASH, SEG_E, and the 0–9 patterns.
  - Digit index constants DIG_ONES..DIG_STAT.
- **Sub-module** `bcd_to_sseg`: combinational nibble → 7-bit active-low pattern, including the E pattern for invalid nibbles. It is instantiated once, on the muxed nibble.
- **Top level**: snapshot register, refresh counter, blanking logic and output registers.

## Test plan
All scenarios use N=4, so each digit is held 4 cycles and a full scan takes 16.
- **Reset**: assert reset for 3 cycles, then release with load=0.
  - During reset: an=1111, sseg=FF, bcd_err=0.
  - Then an cycles 1110 with ones "0"; an[1..3] stay 1 with blank_lz=1.
- **Normal load**: load 12'h038, ovf=0, blank_lz=1.
  - Ones: 0000000 ("8"); tens: 0000110 ("3"); hundreds blanked; status blanked.
  - With blank_lz=0, hundreds shows "0".
- **Overflow**: load 12'h000, ovf=1.
  - Status digit (an=0111) shows sseg=8'b1_1111110.
  - Ones "0"; tens and hundreds blanked with blank_lz=1.
- **Invalid BCD**: load 12'h1A3.
  - bcd_err=1 at the load edge.
  - Tens shows 0110000 ("E"); hundreds "1"; ones "3".
  - Loading 12'h124 clears bcd_err.
- **No tear**: change bcd_in to 12'h999 without load during a scan. The display is unchanged for a full 16-cycle scan.
- **Load mid-digit, then reset mid-scan**: load 12'h130 while sel=1.
  - The tens output updates at the next edge.
  - Asserting reset at cycle 6 of a scan forces an=1111 and sseg=FF immediately, and the snapshot reads 0 afterward.

Source files
------------

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared segment patterns, digit indices and helpers for the
//               BCD seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

  // Active-low a..g patterns, a at bit 6.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_STAT = 2'd3;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  function automatic logic nib_bad(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

  function automatic logic [3:0] an_select(input logic [1:0] dig);
    return ~(4'b0001 << dig);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_sseg
// Description : Combinational BCD nibble to active-low a..g pattern; nibbles
//               above 9 decode to "E".
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_E;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_E;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_sseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sseg_scan
// Description : 4-digit multiplexed seven-segment driver for a latched 3-digit
//               BCD value plus an overflow status digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sseg_scan
  import sseg_pkg::*;
#(
  parameter int N = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] bcd_in,
  input  logic        ovf_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        bcd_err
);

  bcd3_t          r_snap;
  logic           r_ovf;
  logic [N-1:0]   r_cnt;
  logic [3:0]     r_an;
  logic [7:0]     r_sseg;

  logic [1:0]     w_sel;
  logic [3:0]     w_nib;
  logic [6:0]     w_dec;
  logic [6:0]     w_seg;
  logic           w_blank;
  logic [3:0]     w_an_nxt;
  logic [7:0]     w_sseg_nxt;

  assign w_sel = r_cnt[N-1:N-2];

  always_comb begin
    w_nib = 4'h0;
    case (w_sel)
      DIG_ONES: w_nib = r_snap.ones;
      DIG_TENS: w_nib = r_snap.tens;
      DIG_HUND: w_nib = r_snap.hund;
      default:  w_nib = 4'h0;
    endcase
  end

  bcd_to_sseg u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Only genuine zeros blank; an invalid nibble always shows its "E".
  always_comb begin
    w_blank = 1'b0;
    w_seg   = w_dec;
    case (w_sel)
      DIG_TENS: w_blank = blank_lz && (r_snap.hund == 4'h0) && (r_snap.tens == 4'h0);
      DIG_HUND: w_blank = blank_lz && (r_snap.hund == 4'h0);
      DIG_STAT: begin
        w_seg   = SEG_DASH;
        w_blank = !r_ovf;
      end
      default:  w_blank = 1'b0;
    endcase
    w_an_nxt   = w_blank ? 4'b1111 : an_select(w_sel);
    w_sseg_nxt = w_blank ? {1'b1, SEG_BLANK} : {1'b1, w_seg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_an   <= 4'b1111;
      r_sseg <= 8'hFF;
    end else begin
      if (load) begin
        r_snap <= bcd3_t'(bcd_in);
        r_ovf  <= ovf_in;
      end
      r_cnt  <= r_cnt + N'(1);
      r_an   <= w_an_nxt;
      r_sseg <= w_sseg_nxt;
    end
  end

  assign an      = r_an;
  assign sseg    = r_sseg;
  assign bcd_err = nib_bad(r_snap.ones) | nib_bad(r_snap.tens) | nib_bad(r_snap.hund);

endmodule
`default_nettype wire

// File: tb/tb_bcd_sseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_sseg_scan
// Description : Scoreboard bench for bcd_sseg_scan with N=4 (4 cycles/digit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_sseg_scan;

  localparam int N = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        load     = 1'b0;
  logic [11:0] bcd_in   = 12'h000;
  logic        ovf_in   = 1'b0;
  logic        blank_lz = 1'b1;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        bcd_err;

  bcd_sseg_scan #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bcd_in   (bcd_in),
    .ovf_in   (ovf_in),
    .blank_lz (blank_lz),
    .an       (an),
    .sseg     (sseg),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         chk_disp;
    logic [3:0] an;
    logic [7:0] sseg;
    bit         chk_err;
    logic       err;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc   = 0;
  int         base  = 0;
  int         total = 0;
  int         bad   = 0;
  logic [3:0] d_an  [4];
  logic [7:0] d_seg [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever expectation is due for the current cycle.
  always begin
    exp_t e;
    @(negedge clk or posedge reset);
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        if (e.chk_disp) begin
          total++;
          if (an !== e.an || sseg !== e.sseg) begin
            bad++;
            $display("FAIL %s cyc=%0d: got an=%b sseg=%h, want an=%b sseg=%h",
                     e.name, e.cyc, an, sseg, e.an, e.sseg);
          end
        end
        if (e.chk_err) begin
          total++;
          if (bcd_err !== e.err) begin
            bad++;
            $display("FAIL %s_err cyc=%0d: got bcd_err=%b, want %b", e.name, e.cyc, bcd_err, e.err);
          end
        end
      end
    end
  end

  function automatic int sel_of(input int c);
    return ((c - base - 1) % 16) / 4;
  endfunction

  task automatic push(input int c, input bit cd, input logic [3:0] a, input logic [7:0] s,
                      input bit ce, input logic er, input string nm);
    exp_t e;
    e.cyc = c; e.chk_disp = cd; e.an = a; e.sseg = s;
    e.chk_err = ce; e.err = er; e.name = nm;
    q.push_back(e);
  endtask

  task automatic set_dig(input logic [3:0] a0, input logic [7:0] s0,
                         input logic [3:0] a1, input logic [7:0] s1,
                         input logic [3:0] a2, input logic [7:0] s2,
                         input logic [3:0] a3, input logic [7:0] s3);
    d_an[0] = a0; d_seg[0] = s0;
    d_an[1] = a1; d_seg[1] = s1;
    d_an[2] = a2; d_seg[2] = s2;
    d_an[3] = a3; d_seg[3] = s3;
  endtask

  task automatic expect_scan(input int first, input int n, input logic er, input string nm);
    for (int k = 0; k < n; k++) begin
      int s;
      s = sel_of(first + k);
      push(first + k, 1'b1, d_an[s], d_seg[s], 1'b1, er, nm);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v, input logic ov);
    bcd_in = v;
    ovf_in = ov;
    load   = 1'b1;
    tick(1);
    load   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges, then snapshot 0 with leading-zero blanking.
    for (int c = 1; c <= 3; c++) push(c, 1'b1, 4'b1111, 8'hFF, 1'b1, 1'b0, "reset");
    tick(3);
    reset = 1'b0;
    base  = cyc;
    set_dig(4'b1110, 8'h81, 4'b1111, 8'hFF, 4'b1111, 8'hFF, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b0, "reset_scan");
    tick(16);

    do_load(12'h038, 1'b0);
    push(cyc, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, "load038");
    set_dig(4'b1110, 8'h80, 4'b1101, 8'h86, 4'b1111, 8'hFF, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b0, "load038");
    tick(16);

    blank_lz = 1'b0;
    set_dig(4'b1110, 8'h80, 4'b1101, 8'h86, 4'b1011, 8'h81, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b0, "no_blank");
    tick(16);
    blank_lz = 1'b1;

    do_load(12'h000, 1'b1);
    push(cyc, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, "ovf");
    set_dig(4'b1110, 8'h81, 4'b1111, 8'hFF, 4'b1111, 8'hFF, 4'b0111, 8'hFE);
    expect_scan(cyc + 1, 16, 1'b0, "ovf");
    tick(16);

    do_load(12'h1A3, 1'b0);
    push(cyc, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, "invalid_edge");
    set_dig(4'b1110, 8'h86, 4'b1101, 8'hB0, 4'b1011, 8'hCF, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b1, "invalid");
    tick(16);

    do_load(12'h124, 1'b0);
    push(cyc, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, "clear_err_edge");
    set_dig(4'b1110, 8'hCC, 4'b1101, 8'h92, 4'b1011, 8'hCF, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b0, "load124");
    tick(16);

    // New input without load must leave the latched display untouched.
    bcd_in = 12'h999;
    expect_scan(cyc + 1, 16, 1'b0, "no_tear");
    tick(16);

    // Line up so the load edge samples cnt=4 (tens digit selected).
    while ((((cyc + 1) - base - 1) % 16) != 4) tick(1);
    do_load(12'h130, 1'b1);
    push(cyc, 1'b1, 4'b1101, 8'h92, 1'b1, 1'b0, "mid_old_tens");
    push(cyc + 1, 1'b1, 4'b1101, 8'h86, 1'b1, 1'b0, "mid_new_tens");
    tick(1);
    @(negedge clk);
    #2;
    bcd_in = 12'h999;
    load   = 1'b1;
    push(cyc, 1'b1, 4'b1111, 8'hFF, 1'b1, 1'b0, "rst_async");
    reset  = 1'b1;
    push(cyc + 1, 1'b1, 4'b1111, 8'hFF, 1'b1, 1'b0, "rst_hold");
    push(cyc + 2, 1'b1, 4'b1111, 8'hFF, 1'b1, 1'b0, "rst_hold");
    tick(2);
    reset = 1'b0;
    load  = 1'b0;
    base  = cyc;
    set_dig(4'b1110, 8'h81, 4'b1111, 8'hFF, 4'b1111, 8'hFF, 4'b1111, 8'hFF);
    expect_scan(cyc + 1, 16, 1'b0, "post_rst");
    tick(16);

    tick(2);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
